// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller with an mtime/mtimecmp timer, a software interrupt bit
// and a synchronised external line, arbitrated into a single request/acknowledge handshake.
module irq_ctrl #(
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        mmio_valid,
  input  logic        mmio_write,
  input  logic [2:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic        mmio_ready,
  output logic [31:0] mmio_rdata,
  input  logic        ext_irq,
  input  logic        csr_mstatus_mie,
  input  logic [2:0]  csr_mie,
  input  logic        wb_irq_ack,
  output logic        irq_req,
  output logic [4:0]  irq_cause,
  output logic [2:0]  csr_mip
);

  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_MSIP     = 3'd4;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [1:0]  ext_sync_reg;
  logic [63:0] mtime_reg;
  logic [63:0] mtime_next;
  logic [63:0] mtime_inc;
  logic [63:0] mtimecmp_reg;
  logic [63:0] mtimecmp_next;
  logic        msip_reg;
  logic        msip_next;
  logic        mmio_ready_reg;
  logic [31:0] mmio_rdata_reg;
  logic [31:0] rdata_next;
  state_t      state_reg;
  logic        irq_req_reg;
  logic [4:0]  irq_cause_reg;

  logic        wr_en;
  logic        rd_en;
  logic [1:0]  mtime_wr;
  logic [1:0]  mtimecmp_wr;
  logic        meip;
  logic        mtip;
  logic        msip;
  logic [2:0]  eligible;
  logic [4:0]  sel_cause;

  assign wr_en     = mmio_valid & mmio_write;
  assign rd_en     = mmio_valid & ~mmio_write;
  assign mtime_inc = mtime_reg + 64'd1;

  // Any mtime half write freezes the whole counter for that cycle, so the untouched half holds.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      localparam logic [2:0] MTIME_ADDR = 3'(gi);
      localparam logic [2:0] CMP_ADDR   = 3'(gi + 2);

      assign mtime_wr[gi]    = wr_en && (mmio_addr == MTIME_ADDR);
      assign mtimecmp_wr[gi] = wr_en && (mmio_addr == CMP_ADDR);

      assign mtime_next[gi*32 +: 32] = mtime_wr[gi] ? mmio_wdata :
                                       (|mtime_wr)  ? mtime_reg[gi*32 +: 32] :
                                                      mtime_inc[gi*32 +: 32];
      assign mtimecmp_next[gi*32 +: 32] = mtimecmp_wr[gi] ? mmio_wdata : mtimecmp_reg[gi*32 +: 32];
    end
  endgenerate

  assign msip_next = (wr_en && (mmio_addr == ADDR_MSIP)) ? mmio_wdata[0] : msip_reg;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= MTIMECMP_RST;
      msip_reg     <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      msip_reg     <= msip_next;
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd_en) begin
      case (mmio_addr)
        ADDR_MTIME_LO: rdata_next = mtime_reg[31:0];
        ADDR_MTIME_HI: rdata_next = mtime_reg[63:32];
        ADDR_CMP_LO:   rdata_next = mtimecmp_reg[31:0];
        ADDR_CMP_HI:   rdata_next = mtimecmp_reg[63:32];
        ADDR_MSIP:     rdata_next = {31'd0, msip_reg};
        default:       rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mmio_ready_reg <= 1'b0;
      mmio_rdata_reg <= '0;
    end else begin
      mmio_ready_reg <= mmio_valid;
      mmio_rdata_reg <= rdata_next;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync_reg <= '0;
    end else begin
      ext_sync_reg <= {ext_sync_reg[0], ext_irq};
    end
  end

  // MTIP is gated by reset so csr_mip reads zero throughout reset even for a zero MTIMECMP_RST.
  assign meip    = ext_sync_reg[1];
  assign mtip    = reset_n & (mtime_reg >= mtimecmp_reg);
  assign msip    = msip_reg;
  assign csr_mip = {meip, mtip, msip};

  assign eligible = csr_mip & csr_mie & {3{csr_mstatus_mie}};

  always_comb begin
    if (eligible[2]) begin
      sel_cause = CAUSE_MEI;
    end else if (eligible[0]) begin
      sel_cause = CAUSE_MSI;
    end else begin
      sel_cause = CAUSE_MTI;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      irq_req_reg   <= 1'b0;
      irq_cause_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|eligible) begin
            state_reg     <= ST_REQ;
            irq_req_reg   <= 1'b1;
            irq_cause_reg <= sel_cause;
          end
        end
        ST_REQ: begin
          // Acknowledge wins over withdrawal when both happen together.
          if (wb_irq_ack) begin
            state_reg   <= ST_HOLD;
            irq_req_reg <= 1'b0;
          end else if (~|eligible) begin
            state_reg   <= ST_IDLE;
            irq_req_reg <= 1'b0;
          end
        end
        ST_HOLD: begin
          irq_req_reg <= 1'b0;
          if (!csr_mstatus_mie) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          irq_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mmio_ready = mmio_ready_reg;
  assign mmio_rdata = mmio_rdata_reg;
  assign irq_req    = irq_req_reg;
  assign irq_cause  = irq_cause_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-level reference model built from the controller's behavioural rules.
module tb_irq_ctrl;

  logic        clk_core = 1'b0;
  logic        reset_n = 1'b0;
  logic        mmio_valid = 1'b0;
  logic        mmio_write = 1'b0;
  logic [2:0]  mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic        mmio_ready;
  logic [31:0] mmio_rdata;
  logic        ext_irq = 1'b0;
  logic        csr_mstatus_mie = 1'b0;
  logic [2:0]  csr_mie = '0;
  logic        wb_irq_ack = 1'b0;
  logic        irq_req;
  logic [4:0]  irq_cause;
  logic [2:0]  csr_mip;

  always #5 clk_core = ~clk_core;

  irq_ctrl dut (
    .clk_core        (clk_core),
    .reset_n         (reset_n),
    .mmio_valid      (mmio_valid),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_wdata      (mmio_wdata),
    .mmio_ready      (mmio_ready),
    .mmio_rdata      (mmio_rdata),
    .ext_irq         (ext_irq),
    .csr_mstatus_mie (csr_mstatus_mie),
    .csr_mie         (csr_mie),
    .wb_irq_ack      (wb_irq_ack),
    .irq_req         (irq_req),
    .irq_cause       (irq_cause),
    .csr_mip         (csr_mip)
  );

  typedef struct {
    int          cyc;
    logic        is_read;
    logic [2:0]  addr;
    logic [31:0] data;
  } mmio_exp_t;

  typedef struct {
    logic       req;
    logic [4:0] cause;
    logic [2:0] mip;
  } irq_exp_t;

  mmio_exp_t mmio_q[$];
  irq_exp_t  irq_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk_core) cyc <= cyc + 1;

  // Stimulus for the next clock edge
  logic        s_valid = 1'b0;
  logic        s_write = 1'b0;
  logic [2:0]  s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_ext = 1'b0;
  logic        s_mstatus = 1'b0;
  logic [2:0]  s_mie = '0;
  logic        s_ack = 1'b0;

  // Reference model state
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_HOLD = 2;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_meip;
  logic        m_ext_d1;
  int          m_mode;
  logic [4:0]  m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mtime  = '0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip   = 1'b0;
    m_meip   = 1'b0;
    m_ext_d1 = 1'b0;
    m_mode   = M_IDLE;
    m_cause  = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {31'd0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] model_mip();
    return {m_meip, (m_mtime >= m_cmp), m_msip};
  endfunction

  // Called at posedge+1: apply stimulus, advance the model across one edge, queue expectations.
  task automatic tick();
    mmio_exp_t  me;
    irq_exp_t   ie;
    logic [2:0] elig;
    mmio_valid      = s_valid;
    mmio_write      = s_write;
    mmio_addr       = s_addr;
    mmio_wdata      = s_wdata;
    ext_irq         = s_ext;
    csr_mstatus_mie = s_mstatus;
    csr_mie         = s_mie;
    wb_irq_ack      = s_ack;
    if (s_valid) begin
      me.cyc     = cyc + 1;
      me.is_read = !s_write;
      me.addr    = s_addr;
      me.data    = s_write ? 32'd0 : model_read(s_addr);
      mmio_q.push_back(me);
    end
    @(posedge clk_core);
    elig = model_mip() & s_mie & {3{s_mstatus}};
    case (m_mode)
      M_IDLE: if (elig != 3'b000) begin
        m_mode  = M_REQ;
        m_cause = elig[2] ? 5'd11 : (elig[0] ? 5'd3 : 5'd7);
      end
      M_REQ: begin
        if (s_ack) m_mode = M_HOLD;
        else if (elig == 3'b000) m_mode = M_IDLE;
      end
      default: if (!s_mstatus) m_mode = M_IDLE;
    endcase
    if (s_valid && s_write && s_addr == 3'd0) m_mtime[31:0] = s_wdata;
    else if (s_valid && s_write && s_addr == 3'd1) m_mtime[63:32] = s_wdata;
    else m_mtime = m_mtime + 64'd1;
    if (s_valid && s_write && s_addr == 3'd2) m_cmp[31:0] = s_wdata;
    if (s_valid && s_write && s_addr == 3'd3) m_cmp[63:32] = s_wdata;
    if (s_valid && s_write && s_addr == 3'd4) m_msip = s_wdata[0];
    m_meip   = m_ext_d1;
    m_ext_d1 = s_ext;
    ie.req   = (m_mode == M_REQ);
    ie.cause = m_cause;
    ie.mip   = model_mip();
    irq_q.push_back(ie);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mm_wr(input logic [2:0] a, input logic [31:0] d);
    s_valid = 1'b1; s_write = 1'b1; s_addr = a; s_wdata = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic mm_rd(input logic [2:0] a);
    s_valid = 1'b1; s_write = 1'b0; s_addr = a; s_wdata = '0;
    tick();
    s_valid = 1'b0;
  endtask

  always @(negedge clk_core) begin : monitor
    irq_exp_t  ie;
    mmio_exp_t me;
    if (mon_en) begin
      while (irq_q.size() > 0) begin
        ie = irq_q.pop_front();
        check("irq_req", 32'(irq_req), 32'(ie.req));
        if (ie.req) check("irq_cause", 32'(irq_cause), 32'(ie.cause));
        check("csr_mip", 32'(csr_mip), 32'(ie.mip));
      end
      if (mmio_ready === 1'b1) begin
        if (mmio_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mmio_spurious_ready: got ready=1 expected ready=0 (cycle %0d)", cyc);
        end else begin
          me = mmio_q.pop_front();
          check("mmio_ready_cycle", 32'(cyc), 32'(me.cyc));
          if (me.is_read) check("mmio_rdata", mmio_rdata, me.data);
          $display("mmio %s addr=%0d rdata=0x%08h cycle=%0d", me.is_read ? "rd" : "wr",
                   me.addr, mmio_rdata, cyc);
        end
      end else if (mmio_q.size() > 0 && mmio_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL mmio_missing_ready: got ready=%b expected ready=1 (cycle %0d)", mmio_ready, cyc);
        void'(mmio_q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irq_req"}, 32'(irq_req), 32'd0);
    check({tag, "_irq_cause"}, 32'(irq_cause), 32'd0);
    check({tag, "_mmio_ready"}, 32'(mmio_ready), 32'd0);
    check({tag, "_mmio_rdata"}, mmio_rdata, 32'd0);
    check({tag, "_csr_mip"}, 32'(csr_mip), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_core);
    check_reset_outputs("reset");
    @(posedge clk_core);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // mtime must read 0 at the first edge after release
    mm_rd(3'd0);
    mm_rd(3'd2);
    mm_rd(3'd3);

    // Timer interrupt at mtime == 20
    mm_wr(3'd3, 32'd0);
    mm_wr(3'd2, 32'd20);
    mm_wr(3'd0, 32'd0);
    s_mie = 3'b010; s_mstatus = 1'b1;
    idle(24);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    idle(2);
    s_mstatus = 1'b0; tick();
    s_mie = 3'b000;
    idle(1);

    // Priority: external over software, then software alone
    mm_wr(3'd3, 32'hFFFF_FFFF);
    s_mie = 3'b111; s_ext = 1'b1;
    mm_wr(3'd4, 32'd1);
    idle(3);
    s_mstatus = 1'b1;
    idle(3);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    s_ext = 1'b0;
    idle(3);
    s_mstatus = 1'b0; tick();
    s_mstatus = 1'b1;
    idle(3);

    // Withdraw on enable clear, then ack coincident with the clear
    s_mie = 3'b000; tick();
    idle(2);
    s_mie = 3'b001; tick();
    idle(1);
    s_mie = 3'b000; s_ack = 1'b1; tick(); s_ack = 1'b0;
    idle(2);
    s_mstatus = 1'b0; tick();
    idle(1);

    // mtime low-half wrap carries into the high half
    mm_wr(3'd0, 32'hFFFF_FFFF);
    mm_wr(3'd1, 32'd0);
    mm_rd(3'd0);
    mm_rd(3'd1);
    mm_rd(3'd0);
    mm_rd(3'd6);
    mm_wr(3'd6, 32'hDEAD_BEEF);
    mm_rd(3'd6);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      s_write = 1'($urandom_range(0, 1));
      s_addr  = 3'($urandom_range(0, 7));
      if (s_addr == 3'd0 || s_addr == 3'd2) s_wdata = $urandom_range(0, 200);
      else if (s_addr == 3'd1 || s_addr == 3'd3) s_wdata = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
      else s_wdata = $urandom;
      if ($urandom_range(0, 15) == 0) s_ext = ~s_ext;
      if ($urandom_range(0, 7) == 0) s_mie = 3'($urandom_range(0, 7));
      s_mstatus = ($urandom_range(0, 3) != 0);
      s_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    s_valid = 1'b0; s_ack = 1'b0; s_ext = 1'b0;

    // Asynchronous reset in the middle of a request and an access
    s_mstatus = 1'b0; s_mie = 3'b000;
    idle(3);
    s_mie = 3'b001; s_mstatus = 1'b1;
    mm_wr(3'd4, 32'd1);
    idle(3);
    mon_en = 1'b0;
    irq_q.delete();
    mmio_q.delete();
    mmio_valid = 1'b1; mmio_write = 1'b0; mmio_addr = 3'd0;
    @(posedge clk_core);
    #2;
    mmio_valid = 1'b0;
    check("pre_reset_irq_req", 32'(irq_req), 32'd1);
    check("pre_reset_mmio_ready", 32'(mmio_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    s_mie = 3'b000; s_mstatus = 1'b0;
    repeat (3) @(posedge clk_core);
    #1;
    check_reset_outputs("held_reset");
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    mm_rd(3'd0);
    mm_rd(3'd2);
    mm_rd(3'd3);
    mm_rd(3'd1);
    idle(3);

    @(negedge clk_core);
    #1;
    check("mmio_queue_drained", 32'(mmio_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter MTIMECMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF, meaning reset value of mtimecmp.
REQ-002 SHALL have port clk_core, input, 1, the single core clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port mmio_valid, input, 1, MMIO access request.
REQ-005 SHALL have port mmio_write, input, 1, 1=write, 0=read.
REQ-006 SHALL have port mmio_addr, input, 3, register select: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 msip (bit 0).
REQ-007 SHALL have port mmio_wdata, input, 32, write data.
REQ-008 SHALL have port mmio_ready, output, 1, access complete.
REQ-009 SHALL have port mmio_rdata, output, 32, read data, valid while mmio_ready=1.
REQ-010 SHALL have port ext_irq, input, 1, asynchronous level external interrupt.
REQ-011 SHALL have port csr_mstatus_mie, input, 1, mstatus.MIE from CSR file.
REQ-012 SHALL have port csr_mie, input, 3, enables {MEIE, MTIE, MSIE}.
REQ-013 SHALL have port wb_irq_ack, input, 1, writeback took the interrupt this cycle.
REQ-014 SHALL have port irq_req, output, 1, interrupt request to writeback.
REQ-015 SHALL have port irq_cause, output, 5, cause code, valid while irq_req=1.
REQ-016 SHALL have port csr_mip, output, 3, pending bits {MEIP, MTIP, MSIP} for mip reads.

Function
REQ-017 SHALL synchronise ext_irq through two flops; MEIP = synchronised value (2-cycle latency).
REQ-018 SHALL increment 64-bit mtime by 1 every cycle, wrapping 2^64-1 -> 0.
REQ-019 SHALL, on an mtime half write, load that half with mmio_wdata and suppress the increment that cycle; the other half holds.
REQ-020 SHALL set MTIP combinationally = (mtime >= mtimecmp), unsigned 64-bit compare on registered values.
REQ-021 SHALL set MSIP = msip register bit 0; writes to addr 4 load bit 0 only.
REQ-022 SHALL complete each MMIO access in exactly 1 cycle: mmio_ready and registered mmio_rdata asserted the cycle after mmio_valid sampled, for one cycle; a new access is accepted back-to-back.
REQ-023 SHALL return 0 on reads of addr 5-7 and ignore writes there.
REQ-024 SHALL take eligible = csr_mip & csr_mie, gated by csr_mstatus_mie.
REQ-025 SHALL select by fixed priority MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
REQ-026 SHALL implement FSM IDLE, REQ, HOLD.
REQ-027 IDLE: on any eligible source, go REQ next cycle, latching irq_cause from priority select.
REQ-028 REQ: drive irq_req=1 and hold latched irq_cause stable; no re-arbitration while in REQ.
REQ-029 REQ: on wb_irq_ack=1 go HOLD.
REQ-030 REQ: if no source is eligible and wb_irq_ack=0, withdraw (irq_req=0 next cycle) and go IDLE.
REQ-031 SHALL give wb_irq_ack priority over withdrawal when both occur in the same cycle.
REQ-032 HOLD: drive irq_req=0; go IDLE on the first cycle csr_mstatus_mie=0.
REQ-033 SHALL ignore wb_irq_ack outside REQ.
REQ-034 SHALL leave csr_mip independent of FSM state and enables.

Reset
REQ-035 On reset_n=0, SHALL immediately and asynchronously clear mtime, msip, sync flops, and the mmio_ready/mmio_rdata registers, force FSM to IDLE, and set mtimecmp=MTIMECMP_RST.
REQ-036 SHALL hold outputs irq_req=0, irq_cause=0, mmio_ready=0, mmio_rdata=0, csr_mip=0 during reset, including when reset is asserted mid-REQ or mid-access.
REQ-037 After reset release, mtime SHALL read 0 on the first clock edge, then count.

Verification
REQ-038 Timer: mtimecmp=20, csr_mie=3'b010, csr_mstatus_mie=1 -> MTIP when mtime=20; irq_req=1, irq_cause=7 the next cycle; ack -> HOLD; MIE=0 -> IDLE.
REQ-039 Priority: ext_irq and msip=1 together, all enables set -> irq_cause=11; after ack, MIE toggle, ext_irq low -> irq_cause=3.
REQ-040 Withdraw: REQ with cause 3, csr_mie cleared before ack -> irq_req=0 next cycle, FSM IDLE; same test with ack coincident with the clear -> HOLD.
REQ-041 MMIO: write mtime lo=0xFFFF_FFFF, hi=0 -> following reads show increment and carry into hi (0x1 after wrap); addr 6 reads 0, mmio_ready exactly 1 cycle.
REQ-042 Reset: reset_n low mid-REQ asynchronously -> irq_req=0 without a clock edge; after release, mtimecmp reads 0xFFFF_FFFF in both halves.
